// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and types for the Viterbi decoder slice.
//   K, M, S      constraint length, state bits, number of trellis states
//   state_t      trellis state (M bits)
//   tb_state_e   traceback engine FSM states
//   pred()       predecessor of a trellis state given its survivor decision bit
package viterbi_pkg;

  localparam int unsigned K = 5;
  localparam int unsigned M = K - 1;
  localparam int unsigned S = 1 << M;

  typedef logic [M-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    DECODE,
    DRAIN
  } tb_state_e;

  // The decision bit is the state LSB that was shifted out when entering `state`.
  function automatic state_t pred(input state_t state, input logic b);
    return {state[M-2:0], b};
  endfunction

endpackage

// File: rtl/survivor_ram.sv
// survivor_ram: D x S survivor-decision storage for the traceback engine.
//   clk        clock
//   wr_en      write strobe
//   wr_addr    row written
//   wr_data    S decision bits of that row
//   rd_row     row read (combinational)
//   rd_state   state index inside rd_row
//   rd_bit     decision bit of rd_state in rd_row
// No reset: contents are only read after being written.
module survivor_ram #(
  parameter int unsigned D  = 32,
  parameter int unsigned S  = 16,
  parameter int unsigned AW = 5,
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [S-1:0]  wr_data,
  input  logic [AW-1:0] rd_row,
  input  logic [SW-1:0] rd_state,
  output logic          rd_bit
);

  logic [S-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_bit = mem[rd_row][rd_state];

endmodule

// File: rtl/survivor_traceback.sv
// survivor_traceback: survivor-path ring memory plus traceback engine.
// Each traceback walks back TB_LEN rows from the newest row, decodes the next
// BLK rows, releases the BLK oldest rows and then emits those BLK bits oldest
// first over a valid/ready handshake.
//   clk, rst      clock, synchronous active-high reset
//   wr_en         survivor row valid; accepted when wr_en && wr_ready
//   wr_ready      ring not full
//   surv_row      S decision bits, bit s = decision of state s
//   best_state    best-metric state of this row (TB_BEST_STATE_EN only)
//   out_valid     decoded bit valid
//   out_ready     consumer ready
//   out_bit       decoded bit, oldest first
//   busy          traceback engine active
//   occupancy     rows held (written, not yet released)
// Build option: define TB_BEST_STATE_EN to start traceback from the registered
// best state of the newest row instead of state 0.
module survivor_traceback
  import viterbi_pkg::*;
#(
  parameter int unsigned K      = 5,
  parameter int unsigned TB_LEN = 15,
  parameter int unsigned BLK    = 8,
  parameter int unsigned D      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  output logic                   wr_ready,
  input  logic [S-1:0]           surv_row,
  input  logic [M-1:0]           best_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic                   busy,
  output logic [$clog2(D+1)-1:0] occupancy
);

  localparam int unsigned OW   = $clog2(D + 1);
  localparam int unsigned AW   = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CMAX = (TB_LEN > BLK) ? TB_LEN : BLK;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned IW   = (BLK > 1) ? $clog2(BLK) : 1;

  // State width comes from viterbi_pkg; K is kept on the port list only so
  // existing instantiations still elaborate, and must agree with the package.
  if (K != viterbi_pkg::K) begin : g_k_check
    $error("survivor_traceback: K must equal viterbi_pkg::K");
  end
  if (D < TB_LEN + BLK) begin : g_depth_check
    $error("survivor_traceback: D must be >= TB_LEN + BLK");
  end
  if (TB_LEN < 1 || BLK < 1) begin : g_len_check
    $error("survivor_traceback: TB_LEN and BLK must be >= 1");
  end

  tb_state_e      state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, rd_row_q;
  logic [OW-1:0]  occ_q;
  state_t         trel_q, start_state;
  logic [CW-1:0]  step_q;
  logic [IW-1:0]  rd_idx_q, obuf_wr_idx;
  logic [BLK-1:0] obuf_q;

  logic wr_fire, trigger, skip_done, decode_done, drain_done;
  logic walking, drain_fire, ram_bit;

  survivor_ram #(
    .D (D),
    .S (S),
    .AW(AW),
    .SW(M)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (surv_row),
    .rd_row  (rd_row_q),
    .rd_state(trel_q),
    .rd_bit  (ram_bit)
  );

`ifdef TB_BEST_STATE_EN
  state_t best_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
    end else if (wr_fire) begin
      best_q <= best_state;
    end
  end

  assign start_state = best_q;
`else
  logic best_state_unused;

  assign best_state_unused = ^best_state;
  assign start_state       = '0;
`endif

  assign wr_ready   = (occ_q < OW'(D));
  assign wr_fire    = wr_en && wr_ready;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DRAIN);
  assign out_bit    = out_valid ? obuf_q[rd_idx_q] : 1'b0;
  assign occupancy  = occ_q;
  assign walking    = (state_q == SKIP) || (state_q == DECODE);
  assign drain_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    trigger     = 1'b0;
    skip_done   = 1'b0;
    decode_done = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Registered occupancy only: a write in the trigger cycle is not traced.
        if (occ_q >= OW'(TB_LEN + BLK)) begin
          trigger = 1'b1;
          state_d = SKIP;
        end
      end
      SKIP: begin
        if (step_q == CW'(TB_LEN - 1)) begin
          skip_done = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        if (step_q == CW'(BLK - 1)) begin
          decode_done = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready && rd_idx_q == IW'(BLK - 1)) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      occ_q    <= '0;
      rd_row_q <= '0;
      trel_q   <= '0;
      step_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= (wr_ptr_q == AW'(D - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      // Release of the BLK oldest rows happens on the last DECODE step.
      occ_q <= occ_q + OW'(wr_fire) - (decode_done ? OW'(BLK) : '0);
      if (trigger) begin
        rd_row_q <= (wr_ptr_q == '0) ? AW'(D - 1) : wr_ptr_q - AW'(1);
        trel_q   <= start_state;
        step_q   <= '0;
      end else if (walking) begin
        rd_row_q <= (rd_row_q == '0) ? AW'(D - 1) : rd_row_q - AW'(1);
        trel_q   <= pred(trel_q, ram_bit);
        step_q   <= (skip_done || decode_done) ? '0 : step_q + CW'(1);
      end
      if (drain_fire) begin
        rd_idx_q <= drain_done ? '0 : rd_idx_q + IW'(1);
      end
    end
  end

  // Traceback produces bits newest first; store reversed so DRAIN reads 0..BLK-1.
  assign obuf_wr_idx = IW'(BLK - 1) - IW'(step_q);

  always_ff @(posedge clk) begin
    if (state_q == DECODE) begin
      obuf_q[obuf_wr_idx] <= trel_q[M-1];
    end
  end

endmodule

// File: tb/tb_survivor_traceback.sv
module tb_survivor_traceback;

  localparam int unsigned TB_LEN = 15;
  localparam int unsigned BLK    = 8;
  localparam int unsigned D      = 32;
  localparam int unsigned M      = 4;
  localparam int unsigned S      = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         wr_ready;
  logic [S-1:0] surv_row;
  logic [M-1:0] best_state;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         busy;
  logic [5:0]   occupancy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Encoder input sequence, bit t = u_t; u_0..u_7 = 1,0,1,1,0,0,1,0.
  logic [63:0]  seq = 64'hC3A5_96E1_7B28_F04D;
  int unsigned  model_t;
  logic [M-1:0] model_s;

  survivor_traceback #(
    .K     (5),
    .TB_LEN(TB_LEN),
    .BLK   (BLK),
    .D     (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .surv_row  (surv_row),
    .best_state(best_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .busy      (busy),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Encoder model: s_t = {u_t, s_{t-1}[M-1:1]}; row t holds the dropped bit s_{t-1}[0]
  // in every state position, so the true path is recovered from any start state.
  function automatic logic [S-1:0] row_now();
    return model_s[0] ? '1 : '0;
  endfunction

  task automatic advance_model();
    model_s = {seq[model_t], model_s[M-1:1]};
    model_t++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    wr_en      = 1'b0;
    out_ready  = 1'b0;
    surv_row   = '0;
    best_state = '0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    model_t = 0;
    model_s = '0;
  endtask

  task automatic write_model(input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      wr_en    = 1'b1;
      surv_row = row_now();
      @(negedge clk);
      advance_model();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain_check(input int unsigned first_t);
    int unsigned waited;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      waited = 0;
      while (!out_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      n_cmp++;
      if (!out_valid) begin
        n_bad++;
        $display("FAIL drain_timeout: bit %0d of u_%0d block never valid", i, first_t);
        out_ready = 1'b0;
        return;
      end
      if (out_bit !== seq[first_t + i]) begin
        n_bad++;
        $display("FAIL decode_u%0d: got %b want %b", first_t + i, out_bit, seq[first_t + i]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (occupancy !== 6'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bit !== 1'b0) begin n_bad++; $display("FAIL reset_out_bit: got %b want 0", out_bit); end
  endtask

  task automatic test_zero_rows();
    int unsigned lat;
    do_reset();
    for (int unsigned i = 0; i < 23; i++) begin
      wr_en    = 1'b1;
      surv_row = 16'h0000;
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_cmp++; if (occupancy !== 6'd23) begin n_bad++; $display("FAIL zero_occ23: got %0d want 23", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_early: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy_rise: got %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 23) begin n_bad++; $display("FAIL zero_latency: got %0d want 23", lat); end
    n_cmp++; if (occupancy !== 6'd15) begin n_bad++; $display("FAIL zero_occ_release: got %0d want 15", occupancy); end
    out_ready = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      n_cmp++;
      if ({out_valid, out_bit} !== 2'b10) begin
        n_bad++;
        $display("FAIL zero_bit%0d: got valid=%b bit=%b want valid=1 bit=0", i, out_valid, out_bit);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_known_path();
    do_reset();
    write_model(23);
    drain_check(0);
    write_model(8);
    drain_check(8);
    write_model(8);
    drain_check(16);
  endtask

  task automatic test_backpressure();
    int unsigned accepted;
    logic        seen_full;
    logic        rdy;
    do_reset();
    accepted  = 0;
    seen_full = 1'b0;
    for (int unsigned cyc = 0; cyc < 70; cyc++) begin
      wr_en    = 1'b1;
      surv_row = row_now();
      rdy      = wr_ready;
      @(negedge clk);
      if (rdy) begin
        advance_model();
        accepted++;
      end
      if (!wr_ready && !seen_full) begin
        seen_full = 1'b1;
        n_cmp++; if (occupancy !== 6'd32) begin n_bad++; $display("FAIL bp_full_occ: got %0d want 32", occupancy); end
        n_cmp++; if (accepted !== 32) begin n_bad++; $display("FAIL bp_full_count: got %0d want 32", accepted); end
      end
    end
    wr_en = 1'b0;
    n_cmp++; if (seen_full !== 1'b1) begin n_bad++; $display("FAIL bp_never_full: got %b want 1", seen_full); end
    // 32 rows, 8 released by the first traceback, then refilled to 32.
    n_cmp++; if (accepted !== 40) begin n_bad++; $display("FAIL bp_accepted: got %0d want 40", accepted); end
    n_cmp++; if (occupancy !== 6'd32) begin n_bad++; $display("FAIL bp_occ_stalled: got %0d want 32", occupancy); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_stalled: got %b want 1", out_valid); end
    drain_check(0);
    // Next traceback starts from newest row 39 across the ring wrap: u_17..u_24.
    drain_check(17);
    n_cmp++; if (occupancy !== 6'd24) begin n_bad++; $display("FAIL bp_occ_after: got %0d want 24", occupancy); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_wr_ready_after: got %b want 1", wr_ready); end
  endtask

  task automatic test_write_release();
    do_reset();
    write_model(24);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wrrel_busy: got %b want 1", busy); end
    n_cmp++; if (occupancy !== 6'd24) begin n_bad++; $display("FAIL wrrel_occ24: got %0d want 24", occupancy); end
    repeat (22) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL wrrel_valid_early: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 6'd24) begin n_bad++; $display("FAIL wrrel_occ_before: got %0d want 24", occupancy); end
    wr_en    = 1'b1;
    surv_row = row_now();
    @(negedge clk);
    advance_model();
    wr_en = 1'b0;
    n_cmp++; if (occupancy !== 6'd17) begin n_bad++; $display("FAIL wrrel_occ17: got %0d want 17", occupancy); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL wrrel_valid: got %b want 1", out_valid); end
    drain_check(0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_model(23);
    repeat (19) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (occupancy !== 6'd0) begin n_bad++; $display("FAIL rstmid_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
    repeat (30) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_output: got %b want 0", out_valid); end
  endtask

`ifdef TB_BEST_STATE_EN
  task automatic test_best_state();
    logic [S-1:0]   rows [23];
    logic [BLK-1:0] exp_bits;
    logic [M-1:0]   st;
    int             r;
    logic [S-1:0]   row;
    do_reset();
    for (int unsigned i = 0; i < 23; i++) begin
      rows[i] = 16'((i * 40503) + 12345) ^ 16'h5A5A;
    end
    // Reference traceback over the written rows from state 4'hA.
    st = 4'hA;
    r  = 22;
    exp_bits = '0;
    for (int unsigned j = 0; j < TB_LEN + BLK; j++) begin
      row = rows[r];
      if (j >= TB_LEN) exp_bits[BLK - 1 - (j - TB_LEN)] = st[M-1];
      st = {st[M-2:0], row[st]};
      r--;
    end
    for (int unsigned i = 0; i < 23; i++) begin
      wr_en      = 1'b1;
      surv_row   = rows[i];
      best_state = (i == 22) ? 4'hA : 4'h3;
      @(negedge clk);
    end
    wr_en      = 1'b0;
    best_state = '0;
    out_ready  = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      int unsigned waited = 0;
      while (!out_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      n_cmp++;
      if (out_bit !== exp_bits[i] || !out_valid) begin
        n_bad++;
        $display("FAIL best_bit%0d: got valid=%b bit=%b want bit=%b", i, out_valid, out_bit, exp_bits[i]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_rows();
    test_known_path();
    test_backpressure();
    test_write_release();
    test_reset_mid();
`ifdef TB_BEST_STATE_EN
    test_best_state();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
